// File: rtl/ppl_credit_ctrl.sv
// Credit-based valid/ready wrapper around a fixed-latency, non-stallable datapath with an output catch FIFO.
// Defining PPL_CTRL_STATUS_EN adds the inflight_o / fifo_cnt_o status ports.
module ppl_credit_ctrl #(
   parameter int DATA_WIDTH = 32,
   parameter int PIPE_DEPTH = 4,
   parameter int FIFO_DEPTH = 8,
   localparam int CW = $clog2(FIFO_DEPTH + 1)
) (
   input  logic                  clk_i,
   input  logic                  rst_n_i,
   input  logic                  s_valid_i,
   output logic                  s_ready_o,
   input  logic [DATA_WIDTH-1:0] s_data_i,
   output logic [DATA_WIDTH-1:0] pipe_data_o,
   output logic                  pipe_vld_o,
   input  logic [DATA_WIDTH-1:0] pipe_data_i,
   output logic                  m_valid_o,
   input  logic                  m_ready_i,
   output logic [DATA_WIDTH-1:0] m_data_o
`ifdef PPL_CTRL_STATUS_EN
   ,
   output logic [CW-1:0]         inflight_o,
   output logic [CW-1:0]         fifo_cnt_o
`endif
);

   localparam int AW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;

   logic                  acc;
   logic                  pop;
   logic                  ret;
   logic [CW-1:0]         inflight_q, inflight_d;
   logic [CW-1:0]         fifo_cnt_q, fifo_cnt_d;
   logic [AW-1:0]         wr_ptr_q, wr_ptr_d;
   logic [AW-1:0]         rd_ptr_q, rd_ptr_d;
   logic [CW:0]           credits_used;
   logic [DATA_WIDTH-1:0] mem_q [FIFO_DEPTH];

   function automatic logic [AW-1:0] next_ptr(input logic [AW-1:0] p);
      return (FIFO_DEPTH == 1) ? '0 : p + AW'(1);
   endfunction

   // Credits cover both in-flight and queued items, so every return has a free FIFO slot.
   assign credits_used = {1'b0, inflight_q} + {1'b0, fifo_cnt_q};
   assign s_ready_o    = credits_used < (CW+1)'(FIFO_DEPTH);
   assign acc          = s_valid_i & s_ready_o;
   assign pop          = m_valid_o & m_ready_i;
   assign pipe_data_o  = s_data_i;
   assign pipe_vld_o   = acc;
   assign m_valid_o    = (fifo_cnt_q != '0);
   assign m_data_o     = mem_q[rd_ptr_q];

   generate
      if (PIPE_DEPTH == 0) begin : g_no_pipe
         assign ret = acc;
      end else begin : g_vsr
         logic [PIPE_DEPTH-1:0] vsr_q, vsr_d;

         always_comb begin
            vsr_d = (vsr_q << 1) | PIPE_DEPTH'(acc);
         end

         always_ff @(posedge clk_i or negedge rst_n_i) begin
            if (!rst_n_i) begin
               vsr_q <= '0;
            end else begin
               vsr_q <= vsr_d;
            end
         end

         assign ret = vsr_q[PIPE_DEPTH-1];
      end
   endgenerate

   always_comb begin
      inflight_d = inflight_q + CW'(acc) - CW'(ret);
      fifo_cnt_d = fifo_cnt_q + CW'(ret) - CW'(pop);
      wr_ptr_d   = wr_ptr_q;
      rd_ptr_d   = rd_ptr_q;
      if (ret) wr_ptr_d = next_ptr(wr_ptr_q);
      if (pop) rd_ptr_d = next_ptr(rd_ptr_q);
   end

   always_ff @(posedge clk_i or negedge rst_n_i) begin
      if (!rst_n_i) begin
         inflight_q <= '0;
         fifo_cnt_q <= '0;
         wr_ptr_q   <= '0;
         rd_ptr_q   <= '0;
      end else begin
         inflight_q <= inflight_d;
         fifo_cnt_q <= fifo_cnt_d;
         wr_ptr_q   <= wr_ptr_d;
         rd_ptr_q   <= rd_ptr_d;
      end
   end

   // Storage carries no reset; occupancy alone says which entries are meaningful.
   always_ff @(posedge clk_i) begin
      if (ret) mem_q[wr_ptr_q] <= pipe_data_i;
   end

`ifdef PPL_CTRL_STATUS_EN
   assign inflight_o = inflight_q;
   assign fifo_cnt_o = fifo_cnt_q;
`endif

`ifndef SYNTHESIS
   a_no_write_when_full: assert property (@(posedge clk_i) disable iff (!rst_n_i)
      ret |-> (fifo_cnt_q < CW'(FIFO_DEPTH)));
   a_credit_bound: assert property (@(posedge clk_i) disable iff (!rst_n_i)
      credits_used <= (CW+1)'(FIFO_DEPTH));
`endif

endmodule

// File: tb/tb_ppl_credit_ctrl.sv
// Scoreboard bench for ppl_credit_ctrl: u0 wraps a 4-stage delay line (FIFO 8), u1 a zero-depth datapath (FIFO 4).
`timescale 1ns/1ps
module tb_ppl_credit_ctrl;

   typedef struct {
      logic [31:0] data;
      int          vis;
   } exp_t;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        s_valid [2];
   logic [31:0] s_data  [2];
   logic        m_ready [2];
   logic        s_ready [2];
   logic        pipe_vld[2];
   logic        m_valid [2];
   logic [31:0] pipe_do [2];
   logic [31:0] pipe_di [2];
   logic [31:0] m_data  [2];
   logic [31:0] dl      [4];
`ifdef PPL_CTRL_STATUS_EN
   logic [3:0]  infl0, fcnt0;
   logic [2:0]  infl1, fcnt1;
`endif

   exp_t sb [2][$];
   int   checks = 0;
   int   passes = 0;
   int   ecnt = 0;
   int   acc_cnt [2] = '{0, 0};
   int   dut_pop [2] = '{0, 0};

   always #5 clk = ~clk;

   // External datapath for u0: four unreset registers.
   always @(posedge clk) begin
      dl[0] <= pipe_do[0];
      dl[1] <= dl[0];
      dl[2] <= dl[1];
      dl[3] <= dl[2];
   end
   assign pipe_di[0] = dl[3];
   assign pipe_di[1] = pipe_do[1];

   ppl_credit_ctrl #(.DATA_WIDTH(32), .PIPE_DEPTH(4), .FIFO_DEPTH(8)) u0 (
      .clk_i(clk), .rst_n_i(rst_n),
      .s_valid_i(s_valid[0]), .s_ready_o(s_ready[0]), .s_data_i(s_data[0]),
      .pipe_data_o(pipe_do[0]), .pipe_vld_o(pipe_vld[0]), .pipe_data_i(pipe_di[0]),
      .m_valid_o(m_valid[0]), .m_ready_i(m_ready[0]), .m_data_o(m_data[0])
`ifdef PPL_CTRL_STATUS_EN
      , .inflight_o(infl0), .fifo_cnt_o(fcnt0)
`endif
   );

   ppl_credit_ctrl #(.DATA_WIDTH(32), .PIPE_DEPTH(0), .FIFO_DEPTH(4)) u1 (
      .clk_i(clk), .rst_n_i(rst_n),
      .s_valid_i(s_valid[1]), .s_ready_o(s_ready[1]), .s_data_i(s_data[1]),
      .pipe_data_o(pipe_do[1]), .pipe_vld_o(pipe_vld[1]), .pipe_data_i(pipe_di[1]),
      .m_valid_o(m_valid[1]), .m_ready_i(m_ready[1]), .m_data_o(m_data[1])
`ifdef PPL_CTRL_STATUS_EN
      , .inflight_o(infl1), .fifo_cnt_o(fcnt1)
`endif
   );

   function automatic int pd(input int d);
      return (d == 0) ? 4 : 0;
   endfunction

   function automatic int fd(input int d);
      return (d == 0) ? 8 : 4;
   endfunction

   function void chk(input string nm, input longint act, input longint exp);
      checks++;
      if (act == exp) passes++;
      else $display("FAIL %s: got %0h expected %0h (edge %0d)", nm, act, exp, ecnt);
   endfunction

   // One clock: record what the DUTs accept/emit at this edge and log expected outputs.
   task automatic step();
      logic        a [2];
      logic [31:0] dat [2];
      for (int d = 0; d < 2; d++) begin
         a[d]   = rst_n && s_valid[d] && s_ready[d];
         dat[d] = s_data[d];
         if (rst_n && m_valid[d] && m_ready[d]) dut_pop[d]++;
      end
      @(posedge clk);
      ecnt++;
      for (int d = 0; d < 2; d++) begin
         if (a[d]) begin
            sb[d].push_back('{data: dat[d], vis: ecnt + pd(d)});
            acc_cnt[d]++;
         end
      end
      #1;
   endtask

   // Monitor: reference model says an item is in the FIFO once its write edge has passed,
   // and total occupancy is everything accepted but not yet popped.
   always @(negedge clk) begin
      if (rst_n) begin
         for (int d = 0; d < 2; d++) begin
            int   nf;
            logic ev;
            nf = 0;
            for (int i = 0; i < sb[d].size(); i++) if (sb[d][i].vis <= ecnt) nf++;
            ev = (nf > 0);
            chk($sformatf("u%0d.s_ready", d), s_ready[d], sb[d].size() < fd(d));
            chk($sformatf("u%0d.pipe_vld", d), pipe_vld[d], s_valid[d] && (sb[d].size() < fd(d)));
            chk($sformatf("u%0d.m_valid", d), m_valid[d], ev);
            if (ev) chk($sformatf("u%0d.m_data", d), m_data[d], sb[d][0].data);
`ifdef PPL_CTRL_STATUS_EN
            chk($sformatf("u%0d.fifo_cnt", d), (d == 0) ? fcnt0 : {1'b0, fcnt1}, nf);
            chk($sformatf("u%0d.inflight", d), (d == 0) ? infl0 : {1'b0, infl1}, sb[d].size() - nf);
`endif
            if (ev && m_ready[d]) void'(sb[d].pop_front());
         end
      end
   end

   task automatic check_reset_outputs(input string tag);
      for (int d = 0; d < 2; d++) begin
         chk($sformatf("%s.u%0d.s_ready", tag, d), s_ready[d], 1);
         chk($sformatf("%s.u%0d.m_valid", tag, d), m_valid[d], 0);
         chk($sformatf("%s.u%0d.pipe_vld", tag, d), pipe_vld[d], 0);
      end
`ifdef PPL_CTRL_STATUS_EN
      chk({tag, ".u0.inflight"}, infl0, 0);
      chk({tag, ".u0.fifo_cnt"}, fcnt0, 0);
      chk({tag, ".u1.inflight"}, infl1, 0);
      chk({tag, ".u1.fifo_cnt"}, fcnt1, 0);
`endif
   endtask

   // Send one item on DUT d and measure cycles until it shows at the output.
   task automatic send_and_measure(input int d, input logic [31:0] val, input string tag);
      int a0, n;
      a0 = acc_cnt[d];
      s_valid[d] = 1'b1;
      s_data[d]  = val;
      m_ready[d] = 1'b1;
      step();
      s_valid[d] = 1'b0;
      s_data[d]  = 32'hDEAD_0000;
      chk({tag, ".accepted"}, acc_cnt[d] - a0, 1);
      n = 0;
      while (!m_valid[d] && n < 20) begin
         step();
         n++;
      end
      chk({tag, ".latency"}, n + 1, pd(d) + 1);
      chk({tag, ".data"}, m_data[d], val);
   endtask

   initial begin
      int a0, p0;
      s_valid = '{1'b0, 1'b0};
      s_data  = '{32'h0, 32'h0};
      m_ready = '{1'b1, 1'b1};

      rst_n = 1'b0;
      repeat (3) step();
      check_reset_outputs("reset");
      @(negedge clk);
      rst_n = 1'b1;
      repeat (2) step();

      // Single item through the 4-stage datapath
      send_and_measure(0, 32'hA5A5_0001, "t1");
      repeat (3) step();

      // Backpressure fill
      m_ready[0] = 1'b0;
      a0 = acc_cnt[0];
      for (int i = 0; i < 12; i++) begin
         s_valid[0] = 1'b1;
         s_data[0]  = i;
         step();
      end
      s_valid[0] = 1'b0;
      chk("t2.accepted", acc_cnt[0] - a0, 8);
      chk("t2.s_ready_low", s_ready[0], 0);
      repeat (4) step();
      chk("t2.m_valid", m_valid[0], 1);
`ifdef PPL_CTRL_STATUS_EN
      chk("t2.fifo_cnt", fcnt0, 8);
      chk("t2.inflight", infl0, 0);
`endif
      m_ready[0] = 1'b1;
      p0 = dut_pop[0];
      repeat (10) step();
      chk("t2.drained", dut_pop[0] - p0, 8);

      // Randomised streaming
      for (int c = 0; c < 10000; c++) begin
         s_valid[0] = ($urandom_range(0, 99) < 70);
         s_data[0]  = $urandom;
         m_ready[0] = ($urandom_range(0, 99) < 70);
         step();
      end
      s_valid[0] = 1'b0;
      m_ready[0] = 1'b1;
      repeat (20) step();
      chk("t3.empty_after_drain", m_valid[0], 0);

      // Full throughput with both sides always ready
      a0 = acc_cnt[0];
      p0 = dut_pop[0];
      for (int i = 0; i < 1000; i++) begin
         s_valid[0] = 1'b1;
         s_data[0]  = 32'h1000_0000 + i;
         step();
      end
      s_valid[0] = 1'b0;
      repeat (5) step();
      chk("t3.tput_accepted", acc_cnt[0] - a0, 1000);
      chk("t3.tput_completed", dut_pop[0] - p0, 1000);

      // Pointer wrap on the zero-depth instance, write and pop every cycle
      a0 = acc_cnt[1];
      p0 = dut_pop[1];
      m_ready[1] = 1'b1;
      for (int i = 0; i < 20; i++) begin
         s_valid[1] = 1'b1;
         s_data[1]  = i;
         step();
`ifdef PPL_CTRL_STATUS_EN
         chk("t4.fifo_cnt_le2", fcnt1 <= 3'd2, 1);
`endif
      end
      s_valid[1] = 1'b0;
      repeat (4) step();
      chk("t4.accepted", acc_cnt[1] - a0, 20);
      chk("t4.popped", dut_pop[1] - p0, 20);

      // Zero-depth datapath latency
      send_and_measure(1, 32'h0000_1234, "t5");
      repeat (3) step();

      // Reset mid-operation: 3 in flight, 2 queued
      m_ready[0] = 1'b0;
      for (int i = 0; i < 5; i++) begin
         s_valid[0] = 1'b1;
         s_data[0]  = 32'hC0DE_0000 + i;
         step();
      end
      s_valid[0] = 1'b0;
      step();
`ifdef PPL_CTRL_STATUS_EN
      chk("t6.pre_inflight", infl0, 3);
      chk("t6.pre_fifo_cnt", fcnt0, 2);
`endif
      chk("t6.pre_m_valid", m_valid[0], 1);
      #3;
      rst_n = 1'b0;
      #1;
      check_reset_outputs("t6.async");
      sb[0].delete();
      sb[1].delete();
      repeat (2) step();
      @(negedge clk);
      rst_n = 1'b1;
      m_ready[0] = 1'b1;
      repeat (8) step();
      chk("t6.no_stale", m_valid[0], 0);
      send_and_measure(0, 32'h0000_BEEF, "t6");
      repeat (3) step();

      $display("%0d/%0d checks passed", passes, checks);
      $finish;
   end

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation did not finish, %0d/%0d checks passed", passes, checks);
      $fatal(1);
   end

endmodule
